// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// One radix-2 shift-add or restoring shift-subtract step per clock, fixed 33-cycle latency.
module multdiv (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, next_state;
  logic [5:0]  step;
  logic        op_div, neg_res, div_zero, div_ovf;
  logic [31:0] addend;
  logic [31:0] acc_hi, acc_lo;

  logic        start_req, start_edge, last_step;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, shifted, diff;
  logic [63:0] full, prod;
  logic [31:0] quot;

  assign start_req  = ctrl_MULT | ctrl_DIV;
  assign start_edge = start_req && (state != RUN);
  assign last_step  = (step == 6'd32);

  assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  always_comb begin
    add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? addend : 32'd0)};
    shifted = {acc_hi, acc_lo[31]};
    diff    = shifted - {1'b0, addend};
    full    = {acc_hi, acc_lo};
    prod    = neg_res ? (~full + 64'd1) : full;
    quot    = neg_res ? (~acc_lo + 32'd1) : acc_lo;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_req) next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    next_state = start_req ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign data_resultRDY = (state == DONE);

  // Both operations run on magnitudes; the sign is applied on the extra finalize edge (step 32).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step           <= 6'd0;
      op_div         <= 1'b0;
      neg_res        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      addend         <= 32'd0;
      acc_hi         <= 32'd0;
      acc_lo         <= 32'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (start_edge) begin
      step     <= 6'd0;
      op_div   <= ~ctrl_MULT;
      neg_res  <= data_operandA[31] ^ data_operandB[31];
      div_zero <= (data_operandB == 32'd0);
      div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      addend   <= ctrl_MULT ? mag_a : mag_b;
      acc_hi   <= 32'd0;
      acc_lo   <= ctrl_MULT ? mag_b : mag_a;
    end else if (state == RUN) begin
      if (!last_step) begin
        step <= step + 6'd1;
        if (op_div) begin
          acc_hi <= diff[32] ? shifted[31:0] : diff[31:0];
          acc_lo <= {acc_lo[30:0], ~diff[32]};
        end else begin
          acc_hi <= add_sum[32:1];
          acc_lo <= {add_sum[0], acc_lo[31:1]};
        end
      end else if (op_div) begin
        data_result    <= div_zero ? 32'd0 : quot;
        data_exception <= div_zero | div_ovf;
      end else begin
        data_result    <= prod[31:0];
        data_exception <= (prod[63:32] != {32{prod[31]}});
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed plan cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int vectors = 0;
  int miscompares = 0;

  multdiv dut (
    .clock         (clock),
    .resetn        (resetn),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, special cases as stated.
  task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p, q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = 1'b0;
    end
  endtask

  // Called at a negedge; returns just after the start edge E0.
  task automatic apply_stimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Waits for ready (bounded), checks latency and result; returns at the ready negedge.
  task automatic check_output(input string tag, input logic [31:0] exp_r, input logic exp_e,
                              input int inject_at);
    int lat = -1;
    for (int n = 0; n <= 40 && lat < 0; n++) begin
      @(negedge clock);
      if (n == inject_at) begin
        ctrl_DIV = 1'b1;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      if (n == inject_at + 1) ctrl_DIV = 1'b0;
      if (data_resultRDY) lat = n;
    end
    ctrl_DIV = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'd33);
    check({tag, "/result"}, data_result, exp_r);
    check({tag, "/exception"}, {31'd0, data_exception}, {31'd0, exp_e});
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clock);
    check({tag, "/rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  task automatic run_model(input string tag, input logic is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e;
    model(is_div, a, b, r, e);
    apply_stimulus(~is_div, is_div, a, b);
    check_output(tag, r, e, -10);
    check_pulse_end(tag);
  endtask

  initial begin
    int extra_rdy;
    logic [31:0] a, b;
    logic is_div;

    resetn = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1;
    check("reset/result", data_result, 32'd0);
    check("reset/exception", {31'd0, data_exception}, 32'd0);
    check("reset/rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Directed multiply and divide cases
    apply_stimulus(1, 0, 32'h0000_0007, 32'hFFFF_FFFA);
    check_output("mul_7x-6", 32'hFFFF_FFD6, 1'b0, -10);
    check_pulse_end("mul_7x-6");
    apply_stimulus(1, 0, 32'h0001_0000, 32'h0001_0000);
    check_output("mul_ovf", 32'h0000_0000, 1'b1, -10);
    check_pulse_end("mul_ovf");
    apply_stimulus(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_output("mul_-1x-1", 32'h0000_0001, 1'b0, -10);
    check_pulse_end("mul_-1x-1");
    apply_stimulus(0, 1, 32'hFFFF_FFD5, 32'h0000_0005);
    check_output("div_-43/5", 32'hFFFF_FFF8, 1'b0, -10);
    check_pulse_end("div_-43/5");
    apply_stimulus(0, 1, 32'd100, 32'hFFFF_FFF9);
    check_output("div_100/-7", 32'hFFFF_FFF2, 1'b0, -10);
    check_pulse_end("div_100/-7");
    apply_stimulus(0, 1, 32'd100, 32'd0);
    check_output("div_by_0", 32'd0, 1'b1, -10);
    check_pulse_end("div_by_0");
    apply_stimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_min/-1", 32'h8000_0000, 1'b1, -10);
    check_pulse_end("div_min/-1");

    // Divide pulse in mid-run must be ignored, with no second ready pulse afterwards
    apply_stimulus(1, 0, 32'd1234, 32'hFFFF_FF00);
    check_output("mul_ignore_div", 32'hFFFB_2E00, 1'b0, 10);
    extra_rdy = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (data_resultRDY) extra_rdy++;
    end
    check("mul_ignore_div/extra_rdy", 32'(extra_rdy), 32'd0);

    // Back-to-back: the second start lands in the DONE cycle
    apply_stimulus(0, 1, 32'd1000, 32'd7);
    check_output("b2b_first", 32'd142, 1'b0, -10);
    apply_stimulus(1, 0, 32'hFFFF_FFFD, 32'd5);
    check_output("b2b_second", 32'hFFFF_FFF1, 1'b0, -10);
    check_pulse_end("b2b_second");

    // Both controls high: multiply wins
    apply_stimulus(1, 1, 32'd6, 32'd3);
    check_output("both_ctrl", 32'd18, 1'b0, -10);
    check_pulse_end("both_ctrl");

    // Reset in mid-run aborts, then a start on the first edge after release
    apply_stimulus(1, 0, 32'd77, 32'd99);
    repeat (16) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort/result", data_result, 32'd0);
    check("abort/exception", {31'd0, data_exception}, 32'd0);
    check("abort/rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    apply_stimulus(1, 0, 32'd3, 32'd4);
    check_output("after_reset", 32'd12, 1'b0, -10);
    check_pulse_end("after_reset");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      is_div = i[0];
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) begin
        a = {{16{a[31]}}, a[15:0]};
        b = {{16{b[31]}}, b[15:0]};
      end
      if (is_div && (i % 4 == 1)) b = 32'($urandom_range(1, 1000));
      if (is_div && (i % 8 == 3)) b = ~b + 32'd1;
      run_model("rand", is_div, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
